// File: rtl/mips_pkg.sv
// Shared types and defaults for the memory arbiter: FSM/owner enums, widths and the
// memory request payload.
package mips_pkg;

  localparam int unsigned MEM_LAT_DEFAULT    = 1;
  localparam int unsigned STARVE_MAX_DEFAULT = 8;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } mem_req_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive denied debug cycles; clear wins over enable.
module starve_counter
  import mips_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  output logic [STARVE_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != STARVE_W'(MAX))) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (cpu/dbg) arbiter onto one memory port: same-cycle grant in IDLE,
// read latency tracked in RD_WAIT, dbg starvation protection.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  owner_t              owner;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                dbg_first;
  logic                rd_grant;
  mem_req_t            cpu_bus;
  mem_req_t            dbg_bus;
  mem_req_t            mem_bus;

  assign cpu_bus   = '{addr: cpu_addr, wdata: cpu_wdata, wr: cpu_wr};
  assign dbg_bus   = '{addr: dbg_addr, wdata: dbg_wdata, wr: dbg_wr};
  assign dbg_first = (starve_cnt == STARVE_W'(STARVE_MAX));
  assign rd_grant  = (cpu_gnt && !cpu_wr) || (dbg_gnt && !dbg_wr);

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk   (Clk),
    .rst_n (reset),
    .clr   (dbg_gnt || !dbg_req),
    .en    ((state == IDLE) && dbg_req && !dbg_gnt),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_grant) state_nxt = RD_WAIT;
      RD_WAIT: if (lat_cnt <= LAT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is combinational; the memory port is quiet whenever nobody is granted.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    mem_bus = '0;
    if (reset && (state == IDLE)) begin
      if (dbg_req && (dbg_first || !cpu_req)) begin
        dbg_gnt = 1'b1;
        mem_bus = dbg_bus;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
        mem_bus = cpu_bus;
      end
    end
  end

  assign mem_addr  = mem_bus.addr;
  assign mem_wdata = mem_bus.wdata;
  assign mem_wr    = mem_bus.wr;

  // Read tracking: capture mem_rdata on the edge where lat_cnt reaches 0.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      lat_cnt    <= '0;
      owner      <= CPU;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (cpu_gnt && !cpu_wr) begin
          owner   <= CPU;
          lat_cnt <= LAT_W'(MEM_LAT);
        end else if (dbg_gnt && !dbg_wr) begin
          owner   <= DBG;
          lat_cnt <= LAT_W'(MEM_LAT);
        end
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          if (owner == CPU) begin
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= mem_rdata;
          end else begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MEM_LAT=1 and MEM_LAT=2 instances, each with a
// small memory model and a read-return scoreboard.
module tb_mem_arbiter;

  typedef struct {
    logic        dbg;
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  sb_t         sb1[$];
  sb_t         sb2[$];

  // instance 1 (MEM_LAT=1)
  logic        c_req, c_wr, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_wr, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wr;
  logic [31:0] mem1 [256];
  logic [7:0]  rd_idx1 = '0;

  // instance 2 (MEM_LAT=2), cpu port only
  logic        e_req, e_wr, e_gnt, e_rvalid;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        d2_gnt, d2_rvalid;
  logic [31:0] d2_rdata;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;
  logic        m2_wr;
  logic [31:0] mem2 [256];
  logic [7:0]  rd_idx2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(8)) u_dut1 (
    .Clk(clk), .reset(rst_n),
    .cpu_req(c_req), .cpu_wr(c_wr), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_gnt(c_gnt), .cpu_rvalid(c_rvalid), .cpu_rdata(c_rdata),
    .dbg_req(d_req), .dbg_wr(d_wr), .dbg_addr(d_addr), .dbg_wdata(d_wdata),
    .dbg_gnt(d_gnt), .dbg_rvalid(d_rvalid), .dbg_rdata(d_rdata),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_wr(m_wr), .mem_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(8)) u_dut2 (
    .Clk(clk), .reset(rst_n),
    .cpu_req(e_req), .cpu_wr(e_wr), .cpu_addr(e_addr), .cpu_wdata(e_wdata),
    .cpu_gnt(e_gnt), .cpu_rvalid(e_rvalid), .cpu_rdata(e_rdata),
    .dbg_req(1'b0), .dbg_wr(1'b0), .dbg_addr(32'd0), .dbg_wdata(32'd0),
    .dbg_gnt(d2_gnt), .dbg_rvalid(d2_rvalid), .dbg_rdata(d2_rdata),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_wr(m2_wr), .mem_rdata(m2_rdata)
  );

  // Memory models: writes land on the grant edge, reads return the word latched at grant.
  assign m_rdata  = mem1[rd_idx1];
  assign m2_rdata = mem2[rd_idx2];

  always @(posedge clk) begin
    if (m_wr) mem1[m_addr[9:2]] <= m_wdata;
    else if (c_gnt || d_gnt) rd_idx1 <= m_addr[9:2];
    if (m2_wr) mem2[m2_addr[9:2]] <= m2_wdata;
    else if (e_gnt || d2_gnt) rd_idx2 <= m2_addr[9:2];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb1.size() == 0 && sb2.size() == 0) break;
      @(negedge clk);
    end
    check_eq("sb_drain", 32'(sb1.size() + sb2.size()), 32'd0);
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, 32'({c_gnt, d_gnt, c_rvalid, d_rvalid, m_wr}), 32'd0);
    check_eq({tag, "_bus"}, m_addr | m_wdata, 32'd0);
    check_eq({tag, "_rdata"}, c_rdata | d_rdata, 32'd0);
  endtask

  // Read-return monitors: every rvalid must match the head of its scoreboard.
  always @(negedge clk) begin
    sb_t e;
    check_eq("gnt_exclusive1", 32'(c_gnt & d_gnt), 32'd0);
    if (c_rvalid || d_rvalid) begin
      if (sb1.size() == 0) begin
        check_eq("rvalid1_unexpected", 32'({c_rvalid, d_rvalid}), 32'd0);
      end else begin
        e = sb1.pop_front();
        check_eq("rvalid1_port", 32'({c_rvalid, d_rvalid}), e.dbg ? 32'd1 : 32'd2);
        check_eq("rvalid1_cycle", 32'(cyc), 32'(e.due));
        check_eq("rvalid1_data", e.dbg ? d_rdata : c_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    check_eq("gnt_exclusive2", 32'(e_gnt & d2_gnt), 32'd0);
    if (e_rvalid || d2_rvalid) begin
      if (sb2.size() == 0) begin
        check_eq("rvalid2_unexpected", 32'({e_rvalid, d2_rvalid}), 32'd0);
      end else begin
        e = sb2.pop_front();
        check_eq("rvalid2_port", 32'({e_rvalid, d2_rvalid}), 32'd2);
        check_eq("rvalid2_cycle", 32'(cyc), 32'(e.due));
        check_eq("rvalid2_data", e_rdata, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = {16'hA5A5, 16'(i)};
      mem2[i] = {16'h5A5A, 16'(i)};
    end
    mem1[16] = 32'hDEAD_BEEF;
    mem2[1]  = 32'h1111_0004;
    mem2[2]  = 32'h2222_0008;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {c_req, c_wr, d_req, d_wr, e_req, e_wr} = '0;
    {c_addr, c_wdata, d_addr, d_wdata, e_addr, e_wdata} = '0;
    repeat (3) @(posedge clk);

    // Reset state, then a cpu read granted at the first edge with reset released.
    c_req = 1'b1; c_addr = 32'h40;
    @(negedge clk);
    check_quiet("reset_state");
    rst_n = 1'b1;
    #1;
    check_eq("first_gnt", 32'(c_gnt), 32'd1);
    check_eq("first_addr", m_addr, 32'h40);
    check_eq("first_wr", 32'(m_wr), 32'd0);
    sb1.push_back('{dbg: 1'b0, data: 32'hDEAD_BEEF, due: cyc + 2});
    tick();
    c_req = 1'b0;
    drain();
    @(negedge clk);
    check_eq("cpu_rdata_hold", c_rdata, 32'hDEAD_BEEF);
    tick();

    // Both requesting: cpu wins until dbg has been denied 8 times.
    c_req = 1'b1; c_wr = 1'b1; c_addr = 32'h100; c_wdata = 32'hC0C0_0100;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h10;  d_wdata = 32'h0000_0055;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("starve_cpu_gnt_%0d", k), 32'(c_gnt), (k == 8) ? 32'd0 : 32'd1);
      check_eq($sformatf("starve_dbg_gnt_%0d", k), 32'(d_gnt), (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) begin
        check_eq("starve_mem_wr", 32'(m_wr), 32'd1);
        check_eq("starve_mem_addr", m_addr, 32'h10);
        check_eq("starve_mem_wdata", m_wdata, 32'h55);
      end
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // cpu write, then a dbg read granted the following cycle.
    c_req = 1'b1; c_wr = 1'b1; c_addr = 32'h20; c_wdata = 32'h1234;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h44;
    @(negedge clk);
    check_eq("wr_cpu_gnt", 32'({c_gnt, d_gnt}), 32'd2);
    check_eq("wr_mem_wr", 32'(m_wr), 32'd1);
    check_eq("wr_mem_addr", m_addr, 32'h20);
    check_eq("wr_mem_wdata", m_wdata, 32'h1234);
    tick();
    c_req = 1'b0;
    @(negedge clk);
    check_eq("rd_dbg_gnt", 32'({c_gnt, d_gnt}), 32'd1);
    check_eq("rd_dbg_mem_wr", 32'(m_wr), 32'd0);
    check_eq("rd_dbg_addr", m_addr, 32'h44);
    sb1.push_back('{dbg: 1'b1, data: 32'hA5A5_0011, due: cyc + 2});
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check_eq("rd_wait_bus_idle", 32'(m_wr) | m_addr | m_wdata, 32'd0);
    drain();

    // Reset during RD_WAIT drops the pending dbg read.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h48;
    @(negedge clk);
    check_eq("rst_dbg_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 32'h4C;
    @(negedge clk);
    check_eq("rd_wait_no_gnt", 32'({c_gnt, d_gnt}), 32'd0);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_read_reset");
    repeat (2) @(negedge clk);
    check_quiet("held_reset");
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_gnt", 32'(c_gnt), 32'd1);
    check_eq("post_rst_addr", m_addr, 32'h4C);
    sb1.push_back('{dbg: 1'b0, data: 32'hA5A5_0013, due: cyc + 2});
    tick();
    c_req = 1'b0;
    drain();
    check_eq("dbg_rdata_cleared", d_rdata, 32'd0);

    // dbg_req dropped at starve_cnt=5 clears the count.
    c_req = 1'b1; c_wr = 1'b1; c_addr = 32'h200; c_wdata = 32'h0000_0200;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h14;  d_wdata = 32'h0000_0014;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("clr_pre_cpu_gnt_%0d", k), 32'({c_gnt, d_gnt}), 32'd2);
      tick();
    end
    d_req = 1'b0;
    @(negedge clk);
    check_eq("clr_drop_cycle", 32'({c_gnt, d_gnt}), 32'd2);
    tick();
    d_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check_eq($sformatf("clr_post_gnt_%0d", k), 32'({c_gnt, d_gnt}), (k == 8) ? 32'd1 : 32'd2);
      if (k == 8) check_eq("clr_dbg_addr", m_addr, 32'h14);
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // MEM_LAT=2: back-to-back cpu reads 0x4 then 0x8.
    e_req = 1'b1; e_wr = 1'b0; e_addr = 32'h4;
    @(negedge clk);
    check_eq("lat2_gnt0", 32'(e_gnt), 32'd1);
    check_eq("lat2_addr0", m2_addr, 32'h4);
    sb2.push_back('{dbg: 1'b0, data: 32'h1111_0004, due: cyc + 3});
    tick();
    e_addr = 32'h8;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("lat2_wait_gnt_%0d", k), 32'(e_gnt), 32'd0);
      tick();
    end
    @(negedge clk);
    check_eq("lat2_gnt3", 32'(e_gnt), 32'd1);
    check_eq("lat2_rvalid3", 32'(e_rvalid), 32'd1);
    check_eq("lat2_addr3", m2_addr, 32'h8);
    sb2.push_back('{dbg: 1'b0, data: 32'h2222_0008, due: cyc + 3});
    tick();
    e_req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the memory read latency in cycles (range 1..4).
REQ-002 Parameter STARVE_MAX, default 8, SHALL set consecutive denied dbg cycles before dbg priority (range 1..15).
REQ-003 Clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 cpu_req, cpu_wr  in  1 each  SHALL be the CPU access request and write flag (1 = write).
REQ-006 cpu_addr, cpu_wdata  in  32 each  SHALL be the CPU address and write data.
REQ-007 cpu_gnt, cpu_rvalid  out  1 each  SHALL be the CPU grant and read-data-valid pulse.
REQ-008 cpu_rdata  out  32  SHALL be the CPU read data.
REQ-009 dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata SHALL mirror the cpu_* ports, same directions and widths, for the debug/loader port.
REQ-010 mem_addr, mem_wdata  out  32 each; mem_wr  out  1; mem_rdata  in  32  SHALL be the single shared memory port.

Function
REQ-011 FSM states SHALL be IDLE and RD_WAIT.
REQ-012 In IDLE, a request SHALL be granted combinationally in the same cycle (gnt high for exactly one cycle); transfer occurs when req and gnt are both high.
REQ-013 Priority SHALL be cpu over dbg, except dbg wins when starve_cnt == STARVE_MAX.
REQ-014 At most one gnt SHALL be high in any cycle.
REQ-015 During a granted cycle, mem_addr/mem_wdata SHALL equal the winner's addr/wdata and mem_wr SHALL equal the winner's wr flag.
REQ-016 When no grant is active, mem_addr, mem_wdata and mem_wr SHALL be 0.
REQ-017 A granted write SHALL complete in its grant cycle; FSM stays IDLE; no rvalid.
REQ-018 A granted read SHALL move the FSM to RD_WAIT, record the owner, and load lat_cnt with MEM_LAT.
REQ-019 In RD_WAIT, no gnt SHALL be asserted and lat_cnt SHALL decrement each cycle.
REQ-020 When lat_cnt reaches 0, owner rdata SHALL register mem_rdata and owner rvalid SHALL pulse one cycle later, exactly MEM_LAT+1 cycles after the grant; the FSM then returns to IDLE.
REQ-021 Back-to-back reads SHALL be possible: a new grant is allowed in the cycle rvalid is high.
REQ-022 cpu_rdata/dbg_rdata SHALL hold their last value until the next rvalid for that port.
REQ-023 starve_cnt (4 bit) SHALL increment, saturating at STARVE_MAX, in each IDLE cycle where dbg_req=1 and dbg_gnt=0.
REQ-024 starve_cnt SHALL clear on a dbg grant or when dbg_req=0; it SHALL hold in RD_WAIT.
REQ-025 Request withdrawal before grant SHALL be legal and leave no side effect.

Reset
REQ-026 Asserting reset at any time, including mid-RD_WAIT, SHALL force IDLE, lat_cnt=0, starve_cnt=0, all gnt/rvalid/mem_wr=0, rdata=0, mem_addr/mem_wdata=0, and drop any pending read with no rvalid.
REQ-027 The first grant after deassertion SHALL be possible on the first rising edge with reset=1.

Structure
REQ-028 The arb_state_t enum (IDLE, RD_WAIT), the owner_t enum (CPU, DBG), and the MEM_LAT/STARVE_MAX defaults SHALL live in the shared mips_pkg package.
REQ-029 The starvation counter SHALL be one sub-module, starve_counter (saturating, clear/enable inputs); all else is inline.

Verification
REQ-030 CPU read 0x0000_0040 with MEM_LAT=1 and mem_rdata=0xDEAD_BEEF -> cpu_gnt in cycle 0, cpu_rvalid in cycle 2, cpu_rdata=0xDEAD_BEEF.
REQ-031 cpu_req and dbg_req held high together, dbg write 0x10 -> cpu granted first; dbg granted once starve_cnt=8; mem_wr=1 with mem_addr=0x10 in that cycle.
REQ-032 CPU write 0x20/0x1234 -> mem_wr=1, mem_wdata=0x1234 for one cycle; no rvalid; dbg read granted the next cycle.
REQ-033 reset=0 asserted in RD_WAIT after a dbg read grant -> no dbg_rvalid ever; all outputs 0; next cpu read is served normally.
REQ-034 Two consecutive CPU reads 0x4 then 0x8 with MEM_LAT=2 -> rvalid at cycles 3 and 6; data in order; no grant during RD_WAIT.
REQ-035 dbg_req pulsed low at starve_cnt=5 -> counter clears to 0; cpu priority retained.
